// File: rtl/proteus_pkg.sv
// Shared constants and state encoding for the reduced-precision packing controller.
package proteus_pkg;
  localparam int BIT_WIDTH  = 16;
  localparam int SHIFT_BITS = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
endpackage

// File: rtl/packer_mask_gen.sv
// Combinational load-mask generator: P ones rotated left by ptr in a 2*BIT_WIDTH register,
// plus whether the mask spans both halves and which half's top bit it writes.
module packer_mask_gen #(
  parameter int BIT_WIDTH  = proteus_pkg::BIT_WIDTH,
  parameter int SHIFT_BITS = proteus_pkg::SHIFT_BITS
) (
  input  logic [SHIFT_BITS-1:0]  i_ptr,
  input  logic [SHIFT_BITS-1:0]  i_prec,
  output logic [2*BIT_WIDTH-1:0] o_mask,
  output logic                   o_cross,
  output logic                   o_comp,
  output logic                   o_comp_sel
);
  localparam int W = 2 * BIT_WIDTH;

  logic [W-1:0]          base;
  logic [2*W-1:0]        dbl;
  logic [SHIFT_BITS:0]   end_off;

  always_comb begin
    base     = ~({W{1'b1}} << i_prec);
    dbl      = {{W{1'b0}}, base} << i_ptr;
    o_mask   = dbl[W-1:0] | dbl[2*W-1:W];
    // offset within the current half plus length beyond the half size means a second half is touched
    end_off  = (SHIFT_BITS+1)'(i_ptr[SHIFT_BITS-2:0]) + (SHIFT_BITS+1)'(i_prec);
    o_cross  = end_off > (SHIFT_BITS+1)'(BIT_WIDTH);
    o_comp   = o_mask[BIT_WIDTH-1] | o_mask[W-1];
    o_comp_sel = o_mask[W-1];
  end
endmodule

// File: rtl/packer_ctrl.sv
// Packing-register sequencer: fill pointer, load mask, row handshake and flush/drain.
// Optional PACKER_CTRL_STATS_EN adds o_row_count (rows taken since reset).
module packer_ctrl #(
  parameter int BIT_WIDTH  = proteus_pkg::BIT_WIDTH,
  parameter int SHIFT_BITS = proteus_pkg::SHIFT_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SHIFT_BITS-1:0]  i_cfg_prec,
  input  logic                   i_cfg_load,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_flush,
  output logic [SHIFT_BITS-1:0]  o_s,
  output logic [2*BIT_WIDTH-1:0] o_load,
  output logic                   o_row_sel,
  output logic                   o_row_valid,
  input  logic                   i_row_ready,
  output logic                   o_row_last,
  output logic                   o_busy
`ifdef PACKER_CTRL_STATS_EN
  ,output logic [31:0]           o_row_count
`endif
);
  import proteus_pkg::*;

  state_e                  state_q, state_d;
  logic [SHIFT_BITS-1:0]   ptr_q, ptr_d, prec_q, prec_d, s_q, s_d;
  logic                    pend_q, pend_d, sel_q, sel_d, last_q, last_d;
  logic                    owe_q, owe_d, owe_sel_q, owe_sel_d;

  logic [2*BIT_WIDTH-1:0]  mg_mask;
  logic                    mg_cross, mg_comp, mg_comp_sel;
  logic                    drain, pend_eff, blocked, accept;

  packer_mask_gen #(.BIT_WIDTH(BIT_WIDTH), .SHIFT_BITS(SHIFT_BITS)) u_mask (
    .i_ptr(ptr_q), .i_prec(prec_q), .o_mask(mg_mask),
    .o_cross(mg_cross), .o_comp(mg_comp), .o_comp_sel(mg_comp_sel)
  );

  always_comb begin
    drain    = pend_q & i_row_ready;
    // a row drained this cycle frees its half for an accept in the same cycle
    pend_eff = pend_q & ~drain;
    blocked  = pend_eff & (mg_cross | (ptr_q[SHIFT_BITS-1] == sel_q) | mg_comp);
    o_in_ready = (state_q != ST_DRAIN) & ~blocked;
    accept   = i_in_valid & o_in_ready;

    state_d   = state_q;
    ptr_d     = ptr_q;
    prec_d    = prec_q;
    s_d       = s_q;
    pend_d    = pend_eff;
    sel_d     = sel_q;
    last_d    = pend_eff & last_q;
    owe_d     = owe_q;
    owe_sel_d = owe_sel_q;

    if (i_cfg_load && state_q == ST_IDLE)
      prec_d = (i_cfg_prec == '0 || i_cfg_prec > SHIFT_BITS'(BIT_WIDTH)) ?
               SHIFT_BITS'(BIT_WIDTH) : i_cfg_prec;

    if (accept) begin
      ptr_d = ptr_q + prec_q;
      s_d   = ptr_q;
      if (mg_comp) begin
        pend_d = 1'b1;
        sel_d  = mg_comp_sel;
        last_d = 1'b0;
      end
      if (state_q == ST_IDLE) state_d = ST_FILL;
    end

    if (i_flush && state_q != ST_DRAIN) begin
      state_d = ST_DRAIN;
      if (ptr_d[SHIFT_BITS-2:0] != '0) begin
        // partial half: queue it behind any completed half still waiting
        if (pend_d) begin
          owe_d     = 1'b1;
          owe_sel_d = ptr_d[SHIFT_BITS-1];
        end else begin
          pend_d = 1'b1;
          sel_d  = ptr_d[SHIFT_BITS-1];
          last_d = 1'b1;
        end
      end else if (pend_d) begin
        last_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        sel_d  = HALF_LO;
        last_d = 1'b1;
      end
    end

    if (state_q == ST_DRAIN) begin
      if (drain && last_q) begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end else if (!pend_eff && owe_q) begin
        pend_d = 1'b1;
        sel_d  = owe_sel_q;
        last_d = 1'b1;
        owe_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      prec_q    <= SHIFT_BITS'(BIT_WIDTH);
      s_q       <= '0;
      pend_q    <= 1'b0;
      sel_q     <= HALF_LO;
      last_q    <= 1'b0;
      owe_q     <= 1'b0;
      owe_sel_q <= HALF_LO;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      prec_q    <= prec_d;
      s_q       <= s_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      owe_q     <= owe_d;
      owe_sel_q <= owe_sel_d;
    end
  end

  assign o_s         = accept ? ptr_q : s_q;
  assign o_load      = accept ? mg_mask : '0;
  assign o_row_valid = pend_q;
  assign o_row_sel   = pend_q & sel_q;
  assign o_row_last  = pend_q & last_q;
  assign o_busy      = state_q != ST_IDLE;

`ifdef PACKER_CTRL_STATS_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + 32'(drain);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign o_row_count = cnt_q;
`endif
endmodule

// File: tb/tb_packer_ctrl.sv
// Directed bench for packer_ctrl: fill patterns, back-pressure, flush/drain and async reset.
module tb_packer_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  i_cfg_prec;
  logic        i_cfg_load, i_in_valid, i_flush, i_row_ready;
  logic        o_in_ready, o_row_sel, o_row_valid, o_row_last, o_busy;
  logic [4:0]  o_s;
  logic [31:0] o_load;
`ifdef PACKER_CTRL_STATS_EN
  logic [31:0] o_row_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  packer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_prec(i_cfg_prec), .i_cfg_load(i_cfg_load),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_flush(i_flush),
    .o_s(o_s), .o_load(o_load), .o_row_sel(o_row_sel), .o_row_valid(o_row_valid),
    .i_row_ready(i_row_ready), .o_row_last(o_row_last), .o_busy(o_busy)
`ifdef PACKER_CTRL_STATS_EN
    , .o_row_count(o_row_count)
`endif
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_cfg_prec = '0; i_cfg_load = 1'b0; i_in_valid = 1'b0;
    i_flush = 1'b0; i_row_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_prec(input logic [4:0] p);
    i_cfg_prec = p; i_cfg_load = 1'b1;
    tick();
    i_cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({o_s, o_load, o_row_sel, o_row_valid, o_row_last, o_busy} !== 41'd0) begin
      n_bad++; $display("FAIL reset_outs: got %h expected 0", {o_s, o_load, o_row_sel, o_row_valid, o_row_last, o_busy}); end
    n_cmp++; if (o_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", o_in_ready); end
    n_cmp++; if (dut.prec_q !== 5'd16) begin n_bad++; $display("FAIL reset_prec: got %0d expected 16", dut.prec_q); end
  endtask

  task automatic test_p8();
    logic [31:0] exp_m [4] = '{32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000};
    logic        exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    set_prec(5'd8);
    i_row_ready = 1'b1; i_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (o_load !== exp_m[i]) begin n_bad++; $display("FAIL p8_mask%0d: got %h expected %h", i, o_load, exp_m[i]); end
      n_cmp++; if (o_s !== 5'(8*i)) begin n_bad++; $display("FAIL p8_s%0d: got %0d expected %0d", i, o_s, 8*i); end
      n_cmp++; if (o_row_valid !== exp_v[i] || (exp_v[i] && o_row_sel !== 1'b0)) begin
        n_bad++; $display("FAIL p8_row%0d: got v=%b s=%b expected v=%b s=0", i, o_row_valid, o_row_sel, exp_v[i]); end
      tick();
    end
    i_in_valid = 1'b0; #1;
    n_cmp++; if (o_row_valid !== 1'b1 || o_row_sel !== 1'b1) begin
      n_bad++; $display("FAIL p8_row_hi: got v=%b s=%b expected v=1 s=1", o_row_valid, o_row_sel); end
    n_cmp++; if (dut.ptr_q !== 5'd0) begin n_bad++; $display("FAIL p8_ptr: got %0d expected 0", dut.ptr_q); end
    n_cmp++; if (o_s !== 5'd24) begin n_bad++; $display("FAIL p8_s_hold: got %0d expected 24", o_s); end
    tick();
`ifdef PACKER_CTRL_STATS_EN
    n_cmp++; if (o_row_count !== 32'd2) begin n_bad++; $display("FAIL p8_count: got %0d expected 2", o_row_count); end
`endif
  endtask

  task automatic test_p5();
    do_reset();
    set_prec(5'd5);
    i_row_ready = 1'b1; i_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (o_load !== (32'h1F << (5*i))) begin
        n_bad++; $display("FAIL p5_mask%0d: got %h expected %h", i, o_load, 32'h1F << (5*i)); end
      tick();
    end
    i_in_valid = 1'b0; #1;
    n_cmp++; if (o_row_valid !== 1'b1 || o_row_sel !== 1'b0) begin
      n_bad++; $display("FAIL p5_row: got v=%b s=%b expected v=1 s=0", o_row_valid, o_row_sel); end
    n_cmp++; if (dut.ptr_q !== 5'd20) begin n_bad++; $display("FAIL p5_ptr: got %0d expected 20", dut.ptr_q); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_prec(5'd12);
    i_row_ready = 1'b0; i_in_valid = 1'b1;
    #1;
    n_cmp++; if (o_load !== 32'h00000FFF) begin n_bad++; $display("FAIL p12_mask0: got %h expected 00000fff", o_load); end
    tick(); #1;
    n_cmp++; if (o_load !== 32'h00FFF000) begin n_bad++; $display("FAIL p12_mask1: got %h expected 00fff000", o_load); end
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (o_in_ready !== 1'b0 || o_load !== 32'd0) begin
        n_bad++; $display("FAIL p12_stall%0d: got rdy=%b load=%h expected rdy=0 load=0", i, o_in_ready, o_load); end
      n_cmp++; if (o_row_valid !== 1'b1 || o_row_sel !== 1'b0) begin
        n_bad++; $display("FAIL p12_pend%0d: got v=%b s=%b expected v=1 s=0", i, o_row_valid, o_row_sel); end
      tick();
    end
    i_row_ready = 1'b1; #1;
    n_cmp++; if (o_in_ready !== 1'b1 || o_load !== 32'hFF00000F || o_s !== 5'd24) begin
      n_bad++; $display("FAIL p12_release: got rdy=%b load=%h s=%0d expected rdy=1 load=ff00000f s=24", o_in_ready, o_load, o_s); end
    tick();
    i_in_valid = 1'b0; i_row_ready = 1'b0; #1;
    n_cmp++; if (o_row_valid !== 1'b1 || o_row_sel !== 1'b1 || dut.ptr_q !== 5'd4) begin
      n_bad++; $display("FAIL p12_after: got v=%b s=%b ptr=%0d expected v=1 s=1 ptr=4", o_row_valid, o_row_sel, dut.ptr_q); end
  endtask

  task automatic test_flush();
    do_reset();
    set_prec(5'd3);
    i_row_ready = 1'b0; i_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (o_load !== (32'h7 << (3*i))) begin
        n_bad++; $display("FAIL p3_mask%0d: got %h expected %h", i, o_load, 32'h7 << (3*i)); end
      tick();
    end
    i_in_valid = 1'b0; i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (o_row_valid !== 1'b1 || o_row_sel !== 1'b0 || o_row_last !== 1'b1) begin
        n_bad++; $display("FAIL flush_row%0d: got v=%b s=%b l=%b expected v=1 s=0 l=1", i, o_row_valid, o_row_sel, o_row_last); end
      n_cmp++; if (o_in_ready !== 1'b0 || o_busy !== 1'b1 || o_load !== 32'd0) begin
        n_bad++; $display("FAIL flush_drain%0d: got rdy=%b busy=%b load=%h expected 0 1 0", i, o_in_ready, o_busy, o_load); end
      tick();
    end
    i_in_valid = 1'b0; i_row_ready = 1'b1;
    tick();
    n_cmp++; if (o_busy !== 1'b0 || o_row_valid !== 1'b0 || o_in_ready !== 1'b1 || dut.ptr_q !== 5'd0) begin
      n_bad++; $display("FAIL flush_idle: got busy=%b v=%b rdy=%b ptr=%0d expected 0 0 1 0", o_busy, o_row_valid, o_in_ready, dut.ptr_q); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_prec(5'd8);
    i_row_ready = 1'b0; i_in_valid = 1'b1;
    tick(); tick();
    i_in_valid = 1'b0; #1;
    n_cmp++; if (o_row_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pend: got %b expected 1", o_row_valid); end
    rst_n = 1'b0; #1;
    n_cmp++; if (o_row_valid !== 1'b0 || dut.ptr_q !== 5'd0 || dut.prec_q !== 5'd16) begin
      n_bad++; $display("FAIL ar_clear: got v=%b ptr=%0d P=%0d expected 0 0 16", o_row_valid, dut.ptr_q, dut.prec_q); end
    tick();
    rst_n = 1'b1;
    set_prec(5'd4);
    i_in_valid = 1'b1; #1;
    n_cmp++; if (o_load !== 32'h0000000F) begin n_bad++; $display("FAIL ar_p4_mask: got %h expected 0000000f", o_load); end
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic test_cfg();
    do_reset();
    set_prec(5'd0);
    i_in_valid = 1'b1; i_row_ready = 1'b1; #1;
    n_cmp++; if (o_load !== 32'h0000FFFF) begin n_bad++; $display("FAIL cfg_p0_mask: got %h expected 0000ffff", o_load); end
    tick();
    i_cfg_prec = 5'd4; i_cfg_load = 1'b1; #1;
    n_cmp++; if (o_load !== 32'hFFFF0000) begin n_bad++; $display("FAIL cfg_ignored_fill: got %h expected ffff0000", o_load); end
    tick();
    i_cfg_load = 1'b0; i_in_valid = 1'b0; #1;
    n_cmp++; if (dut.prec_q !== 5'd16) begin n_bad++; $display("FAIL cfg_prec_hold: got %0d expected 16", dut.prec_q); end
  endtask

  initial begin
    test_reset();
    test_p8();
    test_p5();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end
endmodule
